// File: rtl/multisim_axi_pull_server.sv
// AXI manager whose AW/W/AR beats are pulled from, and B/R beats pushed to, a remote client.
// Each client call is a combinational request (_c) answered in the same cycle and taken at posedge.

module multisim_pull_chan #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         started_i,
  output logic         pull_c_o,
  input  logic         avail_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] payload_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] payload_q, payload_d;

  // Pull whenever the output slot is empty or being consumed this edge.
  assign pull_c_o = started_i & ~rst & (~valid_q | ready_i);

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (pull_c_o) begin
      valid_d = avail_i;
      if (avail_i) payload_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;
endmodule

module multisim_push_chan #(
  parameter int unsigned W              = 32,
  parameter bit          DATA_IS_4STATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         started_i,
  input  logic         start_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         push_c_o,
  output logic [W-1:0] push_data_c_o,
  input  logic         ack_i
);
  logic         ready_q, ready_d;
  logic         pend_q, pend_d;
  logic [W-1:0] skid_q, skid_d;
  logic [W-1:0] sel;

  // A refused beat is retried from the skid register until the client takes it.
  assign sel      = pend_q ? skid_q : data_i;
  assign push_c_o = started_i & ~rst & (pend_q | (valid_i & ready_q));

  if (DATA_IS_4STATE) begin : g_4state
    assign push_data_c_o = sel;
  end else begin : g_2state
    bit [W-1:0] sel_2s;
    assign sel_2s        = sel;
    assign push_data_c_o = sel_2s;
  end

  always_comb begin
    pend_d = pend_q;
    skid_d = skid_q;
    if (push_c_o) begin
      pend_d = ~ack_i;
      if (!ack_i) skid_d = push_data_c_o;
    end
    ready_d = (started_i | start_i) & ~pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      pend_q  <= 1'b0;
      skid_q  <= '0;
    end else begin
      ready_q <= ready_d;
      pend_q  <= pend_d;
      skid_q  <= skid_d;
    end
  end

  assign ready_o = ready_q;
endmodule

module multisim_axi_pull_server #(
  parameter bit          DATA_IS_4STATE = 1'b0,
  parameter int unsigned W_AW           = 32,
  parameter int unsigned W_W            = 32,
  parameter int unsigned W_B            = 32,
  parameter int unsigned W_AR           = 32,
  parameter int unsigned W_R            = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rst_ni,
  output logic            start_c_o,
  output logic [W_AW-1:0] o_axi_m_aw,
  input  logic            i_axi_m_awready,
  output logic            o_axi_m_awvalid,
  output logic            aw_pull_c_o,
  input  logic            aw_avail_i,
  input  logic [W_AW-1:0] aw_data_i,
  output logic [W_W-1:0]  o_axi_m_w,
  input  logic            i_axi_m_wready,
  output logic            o_axi_m_wvalid,
  output logic            w_pull_c_o,
  input  logic            w_avail_i,
  input  logic [W_W-1:0]  w_data_i,
  input  logic [W_B-1:0]  i_axi_m_b,
  output logic            o_axi_m_bready,
  input  logic            i_axi_m_bvalid,
  output logic            b_push_c_o,
  output logic [W_B-1:0]  b_push_data_c_o,
  input  logic            b_ack_i,
  output logic [W_AR-1:0] o_axi_m_ar,
  input  logic            i_axi_m_arready,
  output logic            o_axi_m_arvalid,
  output logic            ar_pull_c_o,
  input  logic            ar_avail_i,
  input  logic [W_AR-1:0] ar_data_i,
  input  logic [W_R-1:0]  i_axi_m_r,
  output logic            o_axi_m_rready,
  input  logic            i_axi_m_rvalid,
  output logic            r_push_c_o,
  output logic [W_R-1:0]  r_push_data_c_o,
  input  logic            r_ack_i
);
  logic started_q;

  // Started survives the functional reset; only power-on clears it, so start is announced once.
  assign start_c_o = rst_ni & ~rst & ~started_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)        started_q <= 1'b0;
    else if (start_c_o) started_q <= 1'b1;
  end

  multisim_pull_chan #(.W(W_AW)) u_aw (
    .clk(clk), .rst(rst), .started_i(started_q),
    .pull_c_o(aw_pull_c_o), .avail_i(aw_avail_i), .data_i(aw_data_i),
    .valid_o(o_axi_m_awvalid), .ready_i(i_axi_m_awready), .payload_o(o_axi_m_aw)
  );

  multisim_pull_chan #(.W(W_W)) u_w (
    .clk(clk), .rst(rst), .started_i(started_q),
    .pull_c_o(w_pull_c_o), .avail_i(w_avail_i), .data_i(w_data_i),
    .valid_o(o_axi_m_wvalid), .ready_i(i_axi_m_wready), .payload_o(o_axi_m_w)
  );

  multisim_pull_chan #(.W(W_AR)) u_ar (
    .clk(clk), .rst(rst), .started_i(started_q),
    .pull_c_o(ar_pull_c_o), .avail_i(ar_avail_i), .data_i(ar_data_i),
    .valid_o(o_axi_m_arvalid), .ready_i(i_axi_m_arready), .payload_o(o_axi_m_ar)
  );

  multisim_push_chan #(.W(W_B), .DATA_IS_4STATE(DATA_IS_4STATE)) u_b (
    .clk(clk), .rst(rst), .started_i(started_q), .start_i(start_c_o),
    .valid_i(i_axi_m_bvalid), .data_i(i_axi_m_b), .ready_o(o_axi_m_bready),
    .push_c_o(b_push_c_o), .push_data_c_o(b_push_data_c_o), .ack_i(b_ack_i)
  );

  multisim_push_chan #(.W(W_R), .DATA_IS_4STATE(DATA_IS_4STATE)) u_r (
    .clk(clk), .rst(rst), .started_i(started_q), .start_i(start_c_o),
    .valid_i(i_axi_m_rvalid), .data_i(i_axi_m_r), .ready_o(o_axi_m_rready),
    .push_c_o(r_push_c_o), .push_data_c_o(r_push_data_c_o), .ack_i(r_ack_i)
  );
endmodule

// File: tb/tb_multisim_axi_pull_server.sv
// Directed bench: a small client model (pull queues, push logs) around multisim_axi_pull_server.
module tb_multisim_axi_pull_server;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst, rst_ni;
  logic start_c;
  logic [W-1:0] aw, w, ar, b_in, r_in, b_pd, r_pd;
  logic awready, awvalid, wready, wvalid, arready, arvalid;
  logic bready, bvalid, rready, rvalid;
  logic b_push, r_push, b_ack, r_ack;
  logic [2:0] pull, avail, vld, rdy;
  logic [W-1:0] pdata [3];

  // Client pull queues: index 0=AW, 1=W, 2=AR
  logic [W-1:0] mem [3][16];
  logic [3:0]   head [3] = '{default: 4'd0};
  logic [3:0]   tail [3] = '{default: 4'd0};

  int start_cnt = 0, pre_start = 0;
  int stall_pull [3] = '{default: 0};
  int b_cnt = 0, b_acc = 0, r_cnt = 0;
  logic [W-1:0] b_last = '0, r_last = '0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      avail[c] = head[c] != tail[c];
      pdata[c] = mem[c][head[c]];
    end
  end

  assign vld = {arvalid, wvalid, awvalid};
  assign rdy = {arready, wready, awready};

  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (pull[c] && avail[c]) head[c] <= head[c] + 4'd1;
      if (pull[c] && vld[c] && !rdy[c]) stall_pull[c] <= stall_pull[c] + 1;
    end
    if (start_c) start_cnt <= start_cnt + 1;
    if (start_cnt == 0 && ((|pull) || b_push || r_push)) pre_start <= pre_start + 1;
    if (b_push) begin
      b_cnt  <= b_cnt + 1;
      b_last <= b_pd;
      if (b_ack) b_acc <= b_acc + 1;
    end
    if (r_push) begin
      r_cnt  <= r_cnt + 1;
      r_last <= r_pd;
    end
  end

  multisim_axi_pull_server #(
    .DATA_IS_4STATE(1'b0), .W_AW(W), .W_W(W), .W_B(W), .W_AR(W), .W_R(W)
  ) dut (
    .clk(clk), .rst(rst), .rst_ni(rst_ni), .start_c_o(start_c),
    .o_axi_m_aw(aw), .i_axi_m_awready(awready), .o_axi_m_awvalid(awvalid),
    .aw_pull_c_o(pull[0]), .aw_avail_i(avail[0]), .aw_data_i(pdata[0]),
    .o_axi_m_w(w), .i_axi_m_wready(wready), .o_axi_m_wvalid(wvalid),
    .w_pull_c_o(pull[1]), .w_avail_i(avail[1]), .w_data_i(pdata[1]),
    .i_axi_m_b(b_in), .o_axi_m_bready(bready), .i_axi_m_bvalid(bvalid),
    .b_push_c_o(b_push), .b_push_data_c_o(b_pd), .b_ack_i(b_ack),
    .o_axi_m_ar(ar), .i_axi_m_arready(arready), .o_axi_m_arvalid(arvalid),
    .ar_pull_c_o(pull[2]), .ar_avail_i(avail[2]), .ar_data_i(pdata[2]),
    .i_axi_m_r(r_in), .o_axi_m_rready(rready), .i_axi_m_rvalid(rvalid),
    .r_push_c_o(r_push), .r_push_data_c_o(r_pd), .r_ack_i(r_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic q(input int c, input logic [W-1:0] d);
    mem[c][tail[c]] = d;
    tail[c] = tail[c] + 4'd1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rdy;
    logic         exp_v;
    logic [W-1:0] exp_d;
  } ar_vec_t;
  ar_vec_t tbl [7];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 16'h3333};
    tbl[1] = '{1'b0, 1'b1, 16'h3333};
    tbl[2] = '{1'b0, 1'b1, 16'h3333};
    tbl[3] = '{1'b0, 1'b1, 16'h3333};
    tbl[4] = '{1'b1, 1'b1, 16'h4444};
    tbl[5] = '{1'b1, 1'b0, 16'h0000};
    tbl[6] = '{1'b0, 1'b0, 16'h0000};

    rst = 1'b1; rst_ni = 1'b0;
    awready = 1'b1; wready = 1'b1; arready = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0; b_in = '0; r_in = '0;
    b_ack = 1'b1; r_ack = 1'b1;
    q(0, 16'h1111); q(0, 16'h2222);
    #2 rst_ni = 1'b1;

    // Reset: everything idle, no client traffic
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_valid_ready", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
      chk("reset_no_start", 32'(start_cnt), 32'd0);
    end

    rst = 1'b0;
    step();
    chk("start_once", 32'(start_cnt), 32'd1);
    chk("ready_after_start", 32'({bready, rready}), 32'b11);
    chk("aw_idle_at_start", 32'(awvalid), 32'd0);
    chk("no_call_before_start", 32'(pre_start), 32'd0);

    // Two queued AW beats back to back
    step();
    chk("aw1_valid", 32'(awvalid), 32'd1);
    chk("aw1_data", 32'(aw), 32'h1111);
    step();
    chk("aw2_valid", 32'(awvalid), 32'd1);
    chk("aw2_data", 32'(aw), 32'h2222);
    step();
    chk("aw_drained", 32'(awvalid), 32'd0);

    q(1, 16'h9999);
    step();
    chk("w_valid", 32'(wvalid), 32'd1);
    chk("w_data", 32'(w), 32'h9999);
    step();
    chk("w_drained", 32'(wvalid), 32'd0);

    // AR stall held by arready=0, then accepted
    q(2, 16'h3333); q(2, 16'h4444);
    for (int i = 0; i < 7; i++) begin
      arready = tbl[i].rdy;
      step();
      chk($sformatf("ar_valid_%0d", i), 32'(arvalid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk($sformatf("ar_data_%0d", i), 32'(ar), 32'(tbl[i].exp_d));
    end
    chk("ar_no_stall_pull", 32'(stall_pull[2]), 32'd0);
    chk("ar_pops", 32'(head[2]), 32'd2);

    // B and R streams accepted every cycle
    bvalid = 1'b1; rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in = W'(16'hB000 + i);
      r_in = W'(16'h5000 + i);
      step();
      chk("r_ready_held", 32'(rready), 32'd1);
      chk("b_ready_held", 32'(bready), 32'd1);
      chk("r_push_count", 32'(r_cnt), 32'(i + 1));
      chk("r_push_data", 32'(r_last), 32'(16'h5000 + i));
      chk("b_push_data", 32'(b_last), 32'(16'hB000 + i));
    end
    rvalid = 1'b0;

    // B push refused three times, then accepted
    b_in = 16'hB0B0; b_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b_refused_ready", 32'(bready), 32'd0);
      chk("b_retry_data", 32'(b_last), 32'hB0B0);
      b_in = 16'hDEAD;
    end
    b_ack = 1'b1;
    step();
    chk("b_ready_restored", 32'(bready), 32'd1);
    chk("b_accept_data", 32'(b_last), 32'hB0B0);
    chk("b_push_total", 32'(b_cnt), 32'd8);
    chk("b_accept_total", 32'(b_acc), 32'd5);
    bvalid = 1'b0;
    step();
    chk("b_no_extra_push", 32'(b_cnt), 32'd8);

    // Reset while AW is stalled drops the beat and does not restart
    awready = 1'b0;
    q(0, 16'h7777);
    step();
    chk("aw_stall_load", 32'(aw), 32'h7777);
    step();
    chk("aw_stall_valid", 32'(awvalid), 32'd1);
    rst = 1'b1;
    step();
    chk("aw_reset_valid", 32'(awvalid), 32'd0);
    chk("aw_reset_data", 32'(aw), 32'd0);
    chk("b_reset_ready", 32'(bready), 32'd0);
    rst = 1'b0;
    q(0, 16'h8888);
    step();
    chk("aw_after_reset_data", 32'(aw), 32'h8888);
    chk("aw_after_reset_valid", 32'(awvalid), 32'd1);
    chk("no_restart", 32'(start_cnt), 32'd1);
    chk("bready_after_reset", 32'(bready), 32'd1);
    awready = 1'b1;
    step();
    chk("aw_final_drain", 32'(awvalid), 32'd0);
    chk("aw_no_stall_pull", 32'(stall_pull[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
